// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the programmable clock divider
package clk_div_pkg;

    localparam int CNT_W   = 16;
    localparam int DIV_RST = 4;
    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Length of the high phase; odd divisors get the extra cycle high.
    function automatic logic [31:0] half_hi(input logic [31:0] d);
        half_hi = (d + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ctrl_load_sync.sv
// rtl/clk_div_ctrl_load_sync.sv - pending divisor register with clamp and ack/err pulses
module div_load_sync
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = clk_div_pkg::CNT_W,
    parameter int MIN_DIV = clk_div_pkg::MIN_DIV
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             apply,
    output logic             pending,
    output logic [CNT_W-1:0] pend_val,
    output logic             div_ack,
    output logic             div_err
);

    logic clamp;
    logic take;

    assign clamp = (div_val < CNT_W'(MIN_DIV));
    assign take  = apply & pending;

    // A capture on the apply edge keeps pending set: that value belongs to the next period.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            pend_val <= '0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            div_ack <= take;
            div_err <= div_load & clamp;
            if (div_load) begin
                pend_val <= clamp ? CNT_W'(MIN_DIV) : div_val;
                pending  <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/drain FSM, period counter and registered divided-clock outputs
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = clk_div_pkg::CNT_W,
    parameter int DIV_RST = clk_div_pkg::DIV_RST,
    parameter int MIN_DIV = clk_div_pkg::MIN_DIV
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_div,
    output logic             tick,
    output logic             running
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] d_act, d_nx;
    logic [CNT_W-1:0] pend_val;
    logic             pending;
    logic             wrap, apply, take;
    logic             clk_div_nx, tick_nx, running_nx;

    assign wrap  = (cnt == d_act - CNT_W'(1));
    assign apply = (state == IDLE) | wrap;
    assign take  = apply & pending;
    assign d_nx  = take ? pend_val : d_act;

    div_load_sync #(
        .CNT_W   (CNT_W),
        .MIN_DIV (MIN_DIV)
    ) u_load (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .div_load (div_load),
        .div_val  (div_val),
        .apply    (apply),
        .pending  (pending),
        .pend_val (pend_val),
        .div_ack  (div_ack),
        .div_err  (div_err)
    );

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        clk_div_nx = clk_div;
        tick_nx    = tick;
        running_nx = running;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx   = RUN;
                    cnt_nx     = '0;
                    clk_div_nx = 1'b1;
                    tick_nx    = 1'b0;
                    running_nx = 1'b1;
                end
            end
            RUN, DRAIN: begin
                cnt_nx     = wrap ? '0 : cnt + CNT_W'(1);
                // d_nx only differs from d_act on the wrap edge, where the new period begins.
                clk_div_nx = (32'(cnt_nx) < half_hi(32'(d_nx)));
                tick_nx    = (cnt_nx == d_nx - CNT_W'(1));
                if (en) begin
                    state_nx = RUN;
                end else if ((state == DRAIN) && wrap) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    clk_div_nx = 1'b0;
                    tick_nx    = 1'b0;
                    running_nx = 1'b0;
                end else begin
                    state_nx = DRAIN;
                end
            end
            default: begin
                state_nx   = IDLE;
                cnt_nx     = '0;
                clk_div_nx = 1'b0;
                tick_nx    = 1'b0;
                running_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            d_act   <= CNT_W'(DIV_RST);
            clk_div <= 1'b0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            d_act   <= d_nx;
            clk_div <= clk_div_nx;
            tick    <= tick_nx;
            running <= running_nx;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - randomized and directed bench for clk_div_ctrl against a period-level model
module tb_clk_div_ctrl;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div_val;
    logic        div_load;
    logic        div_ack, div_err, clk_div, tick, running;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: position inside the current period plus active/pending divisor.
    bit m_act, m_drain, m_pend;
    int m_pos, m_d, m_pend_d;
    bit e_clk, e_tick, e_run, e_ack, e_err;

    clk_div_ctrl dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .clk_div  (clk_div),
        .tick     (tick),
        .running  (running)
    );

    always #10 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_drain = 0; m_pend = 0;
        m_pos = 0; m_d = 4; m_pend_d = 0;
        e_clk = 0; e_tick = 0; e_run = 0; e_ack = 0; e_err = 0;
    endtask

    task automatic model_step(input bit s_en, input bit s_load, input int s_val);
        bit eop;
        e_ack = 0;
        e_err = s_load && (s_val < 2);
        if (!m_act) begin
            if (m_pend) begin m_d = m_pend_d; m_pend = 0; e_ack = 1; end
            if (s_en) begin m_act = 1; m_drain = 0; m_pos = 0; end
        end else begin
            eop = (m_pos == m_d - 1);
            if (eop && m_pend) begin m_d = m_pend_d; m_pend = 0; e_ack = 1; end
            m_pos = eop ? 0 : m_pos + 1;
            if (eop && m_drain && !s_en) m_act = 0;
            else m_drain = !s_en;
        end
        if (s_load) begin
            m_pend_d = (s_val < 2) ? 2 : s_val;
            m_pend = 1;
        end
        e_run  = m_act;
        e_clk  = m_act && (m_pos < (m_d + 1) / 2);
        e_tick = m_act && (m_pos == m_d - 1);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".clk_div"}, 32'(clk_div), 32'(e_clk));
        check_eq({tag, ".tick"},    32'(tick),    32'(e_tick));
        check_eq({tag, ".running"}, 32'(running), 32'(e_run));
        check_eq({tag, ".div_ack"}, 32'(div_ack), 32'(e_ack));
        check_eq({tag, ".div_err"}, 32'(div_err), 32'(e_err));
    endtask

    task automatic step(input bit s_en, input bit s_load, input int s_val, input string tag);
        en       = s_en;
        div_load = s_load;
        div_val  = 16'(s_val);
        @(posedge clk1);
        model_step(s_en, s_load, s_val);
        @(negedge clk1);
        check_outputs(tag);
    endtask

    task automatic run_steps(input int n, input bit s_en, input string tag);
        for (int i = 0; i < n; i++) step(s_en, 1'b0, 0, tag);
    endtask

    task automatic wait_pos(input int target, input string tag);
        int budget = 80;
        while (!(m_act && m_pos == target) && budget > 0) begin
            step(1'b1, 1'b0, 0, tag);
            budget--;
        end
        if (budget == 0) check_eq({tag, ".wait_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        bit r_en;
        rst_n = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;
        model_reset();
        #5;
        check_outputs("reset");
        @(negedge clk1);
        rst_n = 1'b1;

        // default D=4: 1100 with tick every 4th cycle
        run_steps(12, 1'b1, "t1");

        // mid-period load of 5
        wait_pos(1, "t2w");
        step(1'b1, 1'b1, 5, "t2load");
        run_steps(16, 1'b1, "t2");

        // clamped load -> D=2
        step(1'b1, 1'b1, 1, "t3load");
        run_steps(12, 1'b1, "t3");

        // back to D=4, drop en at cnt=1, then drain re-entry
        step(1'b1, 1'b1, 4, "t4load");
        run_steps(3, 1'b1, "t4a");
        wait_pos(1, "t4w");
        run_steps(6, 1'b0, "t4drain");
        run_steps(5, 1'b1, "t4b");
        wait_pos(1, "t4w2");
        step(1'b0, 1'b0, 0, "t4c");
        run_steps(8, 1'b1, "t4reenter");

        // two loads in one period: last wins, single ack
        wait_pos(0, "t5w");
        step(1'b1, 1'b1, 6, "t5l1");
        step(1'b1, 1'b1, 3, "t5l2");
        run_steps(12, 1'b1, "t5");
        run_steps(8, 1'b0, "t5stop");
        step(1'b0, 1'b1, 7, "t5idle_load");
        run_steps(2, 1'b0, "t5idle");
        run_steps(16, 1'b1, "t5run7");

        // oversized request overwritten before use, then reset with a pending load
        wait_pos(2, "t6w");
        step(1'b1, 1'b1, 16'hffff, "t6big");
        step(1'b1, 1'b1, 9, "t6load");
        async_reset("t6rst");
        run_steps(12, 1'b1, "t6after");

        // randomized traffic
        r_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int sel;
            int v;
            bit ld;
            if ($urandom_range(0, 24) == 0) r_en = ~r_en;
            ld  = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      v = $urandom_range(0, 1);
            else if (sel == 1) v = $urandom_range(10, 40);
            else               v = $urandom_range(2, 9);
            step(r_en, ld, v, "rnd");
            if ($urandom_range(0, 799) == 0) async_reset("rnd_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
